alu_share_ctrl: RTL
===================

# alu_share_ctrl

Two-port arbiter and sequencer that shares a single `ALU` instance between two requesters, e.g. the execute stage and the branch/address unit. Each port uses a valid/ready request handshake and a valid/ready response handshake. The block grants one request at a time with round-robin priority, registers the operands, runs the ALU for one cycle, then holds the registered result and flags until the owning requester accepts them. It sits between the requesters and the ALU; the ALU itself remains purely combinational.

## Interface
- `NREQ`, 2: number of requester ports. Fixed at 2; it is a parameter for readability only.
- `CNT_W`, 16: width of the completed-operation counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  [1:0]  per-port request valid.
- `req_ready`  out  [1:0]  per-port request accept; at most one bit is high in any cycle.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  32 each  operands for port 0 and port 1.
- `req_sel0`, `req_sel1`  in  1 each  ALUsel per port, passed to the ALU unchanged.
- `req_op0`, `req_op1`  in  5 each  ALUop per port, passed to the ALU unchanged.
- `resp_valid`  out  [1:0]  per-port response valid; at most one bit is high.
- `resp_ready`  in  [1:0]  per-port response accept.
- `resp_result`  out  32  registered ALU result, shared by both ports and qualified by `resp_valid`.
- `resp_carry`, `resp_zero`, `resp_sign`  out  1 each  registered ALU flags.
- `busy`  out  1  high whenever the state is not IDLE.
- `ops_done`  out  CNT_W  count of completed response handshakes; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - If no `req_valid` bit is set, the block stays in IDLE.
  - Otherwise it computes `grant`:
    - If only one port is valid, that port is granted.
    - If both are valid, the port that is not `last_grant` is granted.
  - `req_ready[grant]` is asserted combinationally in the same cycle.
  - On the clock edge the block latches a, b, sel, op and `grant` into operand registers and moves to EXEC.
- **EXEC:**
  - The ALU inputs are driven only from the operand registers.
  - At the clock edge, result, carry, zero and sign are captured into the response registers.
  - `last_grant` is set to `grant`, and the state moves to RESP.
- **RESP:**
  - `resp_valid[grant]` is high.
  - When `resp_ready[grant]` is high, the handshake completes. `ops_done` increments and the state returns to IDLE.
  - When `resp_ready[grant]` is low, the state stays in RESP and all outputs hold steady.
  - `resp_ready` on the non-granted port is ignored.
- No new request is accepted outside IDLE. `req_ready` is 0 in EXEC and RESP.
- Protocol rule: a requester holds valid and its operands stable until ready. If valid is dropped before ready, nothing is recorded and there are no side effects.
- Reset values:
  - `req_ready` = 0, `resp_valid` = 0, `busy` = 0.
  - `resp_result` = 0; `resp_carry`, `resp_zero`, `resp_sign` = 0.
  - `ops_done` = 0.
  - `last_grant` = 1, so port 0 wins the first contention.
- Reset asserted mid-operation (in EXEC or RESP) aborts the operation and discards it. No response is issued and `ops_done` is not incremented.

## Timing
- Request accepted at edge t; `resp_valid` is high from cycle t+2. Minimum latency is 2 cycles.
- Same-cycle response acceptance returns the block to IDLE at t+3. The next request can be accepted in cycle t+3, so maximum throughput is one operation per 3 cycles.
- The response registers change only at the EXEC→RESP edge. They are stable for the whole RESP period, including across a stall.
- `req_ready` has a combinational path from `req_valid`. There is no combinational path from `resp_ready` to any output.
- Under continuous contention the grants alternate strictly 0,1,0,1…

## Structure
- Shared package `alu_pkg`:
  - FSM state enum.
  - ALUop constants `ALU_OP_ADD`, `ALU_OP_SUB`, `ALU_OP_AND`, with values matching the ALU's decoder.
  - The `ALU_W = 32` constant.
- One sub-module: the existing `ALU`, instantiated once. The arbitration and the FSM stay inline. The round-robin grant logic is small enough that it does not warrant its own module.

## Test plan
- **Reset.** Hold `rst_n` = 0 with both ports valid. All outputs must stay 0 and `busy` = 0. After release, port 0 wins first.
- **Single request.**
  - Stimulus: port 0, a = 32'h5, b = 32'h3, op = ALU_OP_ADD, accepted at t.
  - Response: `resp_valid` = 2'b01 at t+2, `resp_result` = 32'h8, flags 0.
  - `ops_done` = 1 after the handshake.
- **Contention.**
  - Stimulus: both ports valid continuously. Port 0 sends SUB 32'h5 − 32'h5; port 1 sends ADD 32'hFFFF_FFFF + 32'h1.
  - Grant order must be 0,1,0,1.
  - Port 0 response: `resp_zero` = 1.
  - Port 1 response: `resp_result` = 0, `resp_carry` = 1, `resp_zero` = 1.
- **Response stall.**
  - Hold `resp_ready` = 0 for 5 cycles with port 1 requesting a new operation.
  - `resp_result` must stay stable and `req_ready` must stay 0.
  - Port 1 is granted in the cycle after the handshake.
- **Reset mid-op.** Assert `rst_n` = 0 during EXEC. No `resp_valid` may appear and `ops_done` must stay unchanged at its prior value.
- **Counter wrap.** With `CNT_W` = 4, run 17 operations. `ops_done` must read 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU controller and the ALU it drives.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [4:0] ALU_OP_ADD = 5'd0;
  localparam logic [4:0] ALU_OP_SUB = 5'd1;
  localparam logic [4:0] ALU_OP_AND = 5'd2;
  localparam logic [4:0] ALU_OP_OR  = 5'd3;
  localparam logic [4:0] ALU_OP_XOR = 5'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ALU.sv
// Purely combinational ALU. sel swaps the operands (b op a) so reverse subtract is available.
module ALU
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             sel,
  input  logic [4:0]       op,
  output logic [ALU_W-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign
);

  logic [ALU_W-1:0] x;
  logic [ALU_W-1:0] y;
  logic [ALU_W:0]   sum;

  always_comb begin
    x      = sel ? b : a;
    y      = sel ? a : b;
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_OP_ADD: begin
        sum    = {1'b0, x} + {1'b0, y};
        result = sum[ALU_W-1:0];
        carry  = sum[ALU_W];
      end
      // carry is the inverted borrow: set when x >= y
      ALU_OP_SUB: begin
        sum    = {1'b0, x} + {1'b0, ~y} + {{ALU_W{1'b0}}, 1'b1};
        result = sum[ALU_W-1:0];
        carry  = sum[ALU_W];
      end
      ALU_OP_AND: result = x & y;
      ALU_OP_OR:  result = x | y;
      ALU_OP_XOR: result = x ^ y;
      default:    result = '0;
    endcase
    zero = (result == '0);
    sign = result[ALU_W-1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one combinational ALU between two requesters.
//   state | meaning
//   IDLE  | waiting for a request; req_ready asserted for the granted port
//   EXEC  | ALU evaluates the registered operands
//   RESP  | registered result offered to the owning port until accepted
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [ALU_W-1:0]  req_a0,
  input  logic [ALU_W-1:0]  req_b0,
  input  logic [ALU_W-1:0]  req_a1,
  input  logic [ALU_W-1:0]  req_b1,
  input  logic              req_sel0,
  input  logic              req_sel1,
  input  logic [4:0]        req_op0,
  input  logic [4:0]        req_op1,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [ALU_W-1:0]  resp_result,
  output logic              resp_carry,
  output logic              resp_zero,
  output logic              resp_sign,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  state_t           state_q, state_d;
  logic             grant_c, grant_q, last_grant_q;
  logic             accept, resp_done;
  logic [ALU_W-1:0] a_q, b_q, result_q, alu_result;
  logic             sel_q, carry_q, zero_q, sign_q;
  logic             alu_carry, alu_zero, alu_sign;
  logic [4:0]       op_q;
  logic [CNT_W-1:0] ops_done_q;

  ALU u_alu (
    .a      (a_q),
    .b      (b_q),
    .sel    (sel_q),
    .op     (op_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero),
    .sign   (alu_sign)
  );

  always_comb begin
    case (req_valid)
      2'b01:   grant_c = 1'b0;
      2'b10:   grant_c = 1'b1;
      2'b11:   grant_c = ~last_grant_q;
      default: grant_c = 1'b0;
    endcase
  end

  assign accept    = (state_q == IDLE) && (|req_valid);
  assign resp_done = (state_q == RESP) && resp_ready[grant_q];

  // rst_n gate keeps req_ready low while reset is held with requests pending
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          if (rst_n) req_ready[grant_c] = 1'b1;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        if (resp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= 1'b0;
      op_q         <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      sign_q       <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= grant_c;
        a_q     <= grant_c ? req_a1   : req_a0;
        b_q     <= grant_c ? req_b1   : req_b0;
        sel_q   <= grant_c ? req_sel1 : req_sel0;
        op_q    <= grant_c ? req_op1  : req_op0;
      end
      if (state_q == EXEC) begin
        result_q     <= alu_result;
        carry_q      <= alu_carry;
        zero_q       <= alu_zero;
        sign_q       <= alu_sign;
        last_grant_q <= grant_q;
      end
      if (resp_done) ops_done_q <= ops_done_q + CNT_W'(1);
    end
  end

  assign resp_result = result_q;
  assign resp_carry  = carry_q;
  assign resp_zero   = zero_q;
  assign resp_sign   = sign_q;
  assign busy        = (state_q != IDLE);
  assign ops_done    = ops_done_q;

endmodule
